// File: rtl/m20k_pkg.sv
// Shared constants and types for the M20K burst read path.
package m20k_pkg;

  localparam int ADDR_W                    = 10;
  localparam int DATA_W                    = 20;
  localparam int M20K_READ_LATENCY         = 2;
  localparam int DEFAULT_READER_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } readerState_e;

endpackage

// File: rtl/m20k_reader_fifo.sv
// Register-based FIFO for returned RAM words; each entry holds {last, data}.
// popData reads as zero while the FIFO is empty so no stale word is exposed.
module m20k_reader_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);
  import m20k_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wrPtr_r;
  logic [PTR_W-1:0] rdPtr_r;
  logic [CNT_W-1:0] count_r;
  logic             pushOk_s;
  logic             popOk_s;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign empty    = (count_r == '0);
  assign full     = (count_r == CNT_W'(DEPTH));
  assign count    = count_r;
  assign pushOk_s = push && !full;
  assign popOk_s  = pop && !empty;
  assign popData  = empty ? '0 : mem_r[rdPtr_r];

  // Storage, pointers and occupancy; push and pop together leave count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_r <= '0;
      rdPtr_r <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (pushOk_s) begin
        mem_r[wrPtr_r] <= pushData;
        wrPtr_r        <= nextPtr(wrPtr_r);
      end
      if (popOk_s) begin
        rdPtr_r <= nextPtr(rdPtr_r);
      end
      case ({pushOk_s, popOk_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/m20k_burst_reader.sv
// Burst read controller for the registered M20K: issues reads under a credit
// limit, realigns returning data and streams it out with an end-of-burst flag.
module m20k_burst_reader #(
  parameter int ADDR_W       = m20k_pkg::ADDR_W,
  parameter int DATA_W       = m20k_pkg::DATA_W,
  parameter int READ_LATENCY = m20k_pkg::M20K_READ_LATENCY,
  parameter int FIFO_DEPTH   = m20k_pkg::DEFAULT_READER_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic [ADDR_W-1:0] reqStartAddr,
  input  logic [ADDR_W:0]   reqCount,
  output logic              readEnable,
  output logic [ADDR_W-1:0] readAddr,
  input  logic [DATA_W-1:0] readData,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outData,
  output logic              outLast
);
  import m20k_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]              state_r;
  logic [ADDR_W-1:0]       readAddr_r;
  logic [ADDR_W:0]         remaining_r;
  logic [READ_LATENCY-1:0] vldPipe_r;
  logic [READ_LATENCY-1:0] lastPipe_r;

  logic [CNT_W-1:0] inFlight_s;
  logic [CNT_W-1:0] fifoCount_s;
  logic [CNT_W:0]   usedSlots_s;
  logic             issue_s;
  logic             issueLast_s;
  logic             pop_s;
  logic             drainDone_s;
  logic             fifoEmpty_s;
  logic             fifoFull_s;
  logic [DATA_W:0]  fifoHead_s;

  // Credit accounting: every issued read owns a FIFO slot until its word is popped
  always_comb begin
    inFlight_s = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inFlight_s = inFlight_s + CNT_W'(vldPipe_r[i]);
    end
    usedSlots_s = {1'b0, inFlight_s} + {1'b0, fifoCount_s};
    issue_s     = (state_r == ST_ISSUE) && (usedSlots_s < (CNT_W + 1)'(FIFO_DEPTH)) && !fifoFull_s;
    issueLast_s = issue_s && (remaining_r == (ADDR_W + 1)'(1));
    pop_s       = !fifoEmpty_s && outReady;
    drainDone_s = (inFlight_s == '0) &&
                  (fifoEmpty_s || ((fifoCount_s == CNT_W'(1)) && pop_s));
  end

  // Burst control: latch the request, walk addresses, then wait for the final pop
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      readAddr_r  <= '0;
      remaining_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (reqValid && (reqCount != '0)) begin
            state_r     <= ST_ISSUE;
            readAddr_r  <= reqStartAddr;
            remaining_r <= reqCount;
          end
        end
        ST_ISSUE: begin
          if (issue_s) begin
            remaining_r <= remaining_r - (ADDR_W + 1)'(1);
            // readAddr keeps the last issued address once the burst is fully issued
            if (issueLast_s) begin
              state_r <= ST_DRAIN;
            end else begin
              readAddr_r <= readAddr_r + ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (drainDone_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // In-flight valid/last pipe; clearing it on reset discards reads still in the RAM
  always_ff @(posedge clk) begin
    if (rst) begin
      vldPipe_r  <= '0;
      lastPipe_r <= '0;
    end else begin
      vldPipe_r[0]  <= issue_s;
      lastPipe_r[0] <= issueLast_s;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vldPipe_r[i]  <= vldPipe_r[i-1];
        lastPipe_r[i] <= lastPipe_r[i-1];
      end
    end
  end

  m20k_reader_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (vldPipe_r[READ_LATENCY-1]),
    .pushData ({lastPipe_r[READ_LATENCY-1], readData}),
    .pop      (pop_s),
    .popData  (fifoHead_s),
    .count    (fifoCount_s),
    .empty    (fifoEmpty_s),
    .full     (fifoFull_s)
  );

  assign reqReady   = (state_r == ST_IDLE);
  assign readEnable = issue_s;
  assign readAddr   = readAddr_r;
  assign outValid   = !fifoEmpty_s;
  assign outData    = fifoHead_s[DATA_W-1:0];
  assign outLast    = fifoHead_s[DATA_W];

endmodule

// File: tb/tb_m20k_burst_reader.sv
// Directed bench for m20k_burst_reader: a queue model of expected words and
// addresses checked every cycle, plus literal expectations per scenario.
module tb_m20k_burst_reader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic [9:0]  reqStartAddr = 10'd0;
  logic [10:0] reqCount = 11'd0;
  logic        readEnable;
  logic [9:0]  readAddr;
  logic [19:0] readData = 20'd0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [19:0] outData;
  logic        outLast;

  m20k_burst_reader dut (
    .clk          (clk),
    .rst          (rst),
    .reqValid     (reqValid),
    .reqReady     (reqReady),
    .reqStartAddr (reqStartAddr),
    .reqCount     (reqCount),
    .readEnable   (readEnable),
    .readAddr     (readAddr),
    .readData     (readData),
    .outValid     (outValid),
    .outReady     (outReady),
    .outData      (outData),
    .outLast      (outLast)
  );

  always #5 clk = ~clk;

  // Registered M20K: address captured on one edge, data registered on the next
  logic [19:0] mem [1024];
  logic [9:0]  ramAddrQ = 10'd0;
  always @(posedge clk) begin
    if (readEnable) ramAddrQ <= readAddr;
    readData <= mem[ramAddrQ];
  end

  int nChecks = 0;
  int nFails  = 0;
  logic [20:0] expQ[$];
  logic [9:0]  addrQ[$];
  logic [20:0] gotQ[$];
  int rdPulses = 0;
  int outstanding = 0;
  logic prevStall = 1'b0;
  logic [20:0] prevWord = 21'd0;

  int a1[3] = '{5, 6, 7};
  int d1[3] = '{15, 18, 21};
  int d2[4] = '{3066, 3069, 0, 3};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model-based compare, every cycle outside reset
  always @(negedge clk) begin
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      check("reqReady", reqReady, expQ.size() == 0);
      if (readEnable) begin
        rdPulses++;
        outstanding++;
        check("credit_bound", outstanding <= DEPTH, 1);
        if (addrQ.size() == 0) check("unexpected_read", readEnable, 0);
        else check("readAddr", readAddr, addrQ.pop_front());
      end
      if (prevStall) begin
        check("hold_valid", outValid, 1);
        check("hold_word", {outLast, outData}, prevWord);
      end
      if (outValid) begin
        if (expQ.size() == 0) begin
          check("unexpected_outValid", outValid, 0);
        end else begin
          check("outData", outData, expQ[0][19:0]);
          check("outLast", outLast, expQ[0][20]);
          if (outReady) void'(expQ.pop_front());
        end
        if (outReady) begin
          gotQ.push_back({outLast, outData});
          outstanding--;
        end
      end else begin
        check("empty_outData", outData, 0);
        check("empty_outLast", outLast, 0);
      end
      prevStall = outValid && !outReady;
      prevWord  = {outLast, outData};
    end
  end

  task automatic waitNeg();
    @(negedge clk);
    #1;
  endtask

  task automatic toPos();
    @(posedge clk);
    #1;
  endtask

  task automatic flushModel();
    expQ.delete();
    addrQ.delete();
    gotQ.delete();
    outstanding = 0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  task automatic sendReq(input logic [9:0] start, input logic [10:0] cnt);
    reqValid     = 1'b1;
    reqStartAddr = start;
    reqCount     = cnt;
    waitNeg();
    check("reqReady_at_request", reqReady, 1);
    @(posedge clk);
    for (int i = 0; i < int'(cnt); i++) begin
      logic [9:0] a;
      a = start + 10'(i);
      expQ.push_back({(i == int'(cnt) - 1), mem[a]});
      addrQ.push_back(a);
    end
    #1;
    reqValid = 1'b0;
    reqCount = 11'd0;
  endtask

  task automatic waitIdle(input int maxCyc);
    int n;
    n = 0;
    while (!(reqReady && expQ.size() == 0 && !outValid) && n < maxCyc) begin
      waitNeg();
      n++;
    end
    check("idle_timeout", n < maxCyc, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int run;
    for (int i = 0; i < 1024; i++) mem[i] = 20'(i * 3);

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    flushModel();
    waitNeg();
    check("rst_reqReady", reqReady, 1);
    check("rst_outValid", outValid, 0);
    check("rst_outLast", outLast, 0);
    check("rst_readEnable", readEnable, 0);
    check("rst_readAddr", readAddr, 0);
    check("rst_outData", outData, 0);

    // Basic burst with pinned latency
    toPos();
    outReady = 1'b1;
    sendReq(10'd5, 11'd3);
    for (int k = 0; k < 3; k++) begin
      waitNeg();
      check("t1_readEnable", readEnable, 1);
      check("t1_readAddr", readAddr, a1[k]);
    end
    for (int k = 0; k < 3; k++) begin
      waitNeg();
      check("t1_outValid", outValid, 1);
      check("t1_outData", outData, d1[k]);
      check("t1_outLast", outLast, k == 2);
    end
    waitNeg();
    check("t1_reqReady_back", reqReady, 1);

    // Address wrap
    toPos();
    gotQ.delete();
    sendReq(10'd1022, 11'd4);
    waitIdle(50);
    check("t2_count", gotQ.size(), 4);
    for (int k = 0; k < ((gotQ.size() < 4) ? gotQ.size() : 4); k++) begin
      check("t2_data", gotQ[k][19:0], d2[k]);
      check("t2_last", gotQ[k][20], k == 3);
    end

    // Backpressure: credits cap issued reads
    toPos();
    gotQ.delete();
    rdPulses = 0;
    outReady = 1'b0;
    sendReq(10'd200, 11'd10);
    repeat (20) waitNeg();
    check("t3_read_pulses", rdPulses, 4);
    check("t3_nothing_popped", gotQ.size(), 0);
    toPos();
    outReady = 1'b1;
    waitIdle(100);
    check("t3_count", gotQ.size(), 10);
    for (int k = 0; k < ((gotQ.size() < 10) ? gotQ.size() : 10); k++) begin
      check("t3_data", gotQ[k][19:0], (200 + k) * 3);
      check("t3_last", gotQ[k][20], k == 9);
    end

    // Zero-length request
    toPos();
    rdPulses = 0;
    sendReq(10'd50, 11'd0);
    repeat (4) begin
      waitNeg();
      check("t4_readEnable", readEnable, 0);
      check("t4_outValid", outValid, 0);
      check("t4_reqReady", reqReady, 1);
    end
    check("t4_read_pulses", rdPulses, 0);

    // Full-depth burst at full throughput
    toPos();
    gotQ.delete();
    sendReq(10'd0, 11'd1024);
    n = 0;
    while (!outValid && n < 20) begin
      waitNeg();
      n++;
    end
    check("t5_first_valid_delay", n, 4);
    run = 0;
    while (outValid && run < 2000) begin
      run++;
      waitNeg();
    end
    check("t5_consecutive_valid", run, 1024);
    waitIdle(20);
    check("t5_count", gotQ.size(), 1024);
    if (gotQ.size() == 1024) begin
      check("t5_first_word", gotQ[0], {1'b0, 20'd0});
      check("t5_last_word", gotQ[1023], {1'b1, 20'd3069});
    end

    // Reset in the middle of a burst
    toPos();
    gotQ.delete();
    sendReq(10'd300, 11'd8);
    n = 0;
    while (gotQ.size() < 3 && n < 50) begin
      waitNeg();
      n++;
    end
    check("t6_three_words", gotQ.size(), 3);
    if (gotQ.size() >= 3) begin
      check("t6_word0", gotQ[0], {1'b0, 20'd900});
      check("t6_word2", gotQ[2], {1'b0, 20'd906});
    end
    toPos();
    rst = 1'b1;
    outReady = 1'b0;
    toPos();
    rst = 1'b0;
    flushModel();
    waitNeg();
    check("t6_outValid_after_rst", outValid, 0);
    check("t6_readEnable_after_rst", readEnable, 0);
    check("t6_outData_after_rst", outData, 0);
    check("t6_reqReady_after_rst", reqReady, 1);
    outReady = 1'b1;
    repeat (8) waitNeg();
    check("t6_no_stale_words", gotQ.size(), 0);
    toPos();
    sendReq(10'd100, 11'd1);
    waitIdle(20);
    check("t6_new_count", gotQ.size(), 1);
    if (gotQ.size() == 1) check("t6_new_word", gotQ[0], {1'b1, 20'd300});

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/m20k_burst_reader.md
Name: m20k_burst_reader

Overview:
Read-side controller for the team's registered 20b x 1024 simple-dual-port M20K with fixed read latency. It accepts a burst request (start address, word count) and drives the RAM read port (readEnable/readAddr). It captures the returning readData and presents it as a valid/ready stream with an end-of-burst flag. A credit scheme bounds in-flight reads, so output backpressure never drops data while full throughput is sustained.

Parameters:
ADDR_W, 10, RAM address width; depth is 2^ADDR_W words
DATA_W, 20, RAM word width
READ_LATENCY, 2, cycles from readEnable/readAddr sampled to readData valid; matches the registered M20K wrapper
FIFO_DEPTH, 4, output buffer entries; must be >= READ_LATENCY+2

Ports:
clk  in  1  single clock for all logic and the RAM
rst  in  1  synchronous, active-high reset
reqValid  in  1  burst request present
reqReady  out  1  request accepted when reqValid&&reqReady
reqStartAddr  in  ADDR_W  first word address
reqCount  in  ADDR_W+1  words to read, 0..2^ADDR_W
readEnable  out  1  RAM read enable
readAddr  out  ADDR_W  RAM read address
readData  in  DATA_W  RAM read data, valid READ_LATENCY cycles after issue
outValid  out  1  outData valid
outReady  in  1  consumer accepts when outValid&&outReady
outData  out  DATA_W  streamed word
outLast  out  1  high with the final word of a burst

Behaviour:
- Reset (rst sampled high at posedge): state=IDLE; credits, in-flight pipe and FIFO cleared. The next cycle has reqReady=1 and outValid=0, outLast=0, readEnable=0, readAddr=0; outData=0 while empty.
- Reset mid-burst: the burst is abandoned. Reads still in flight are discarded because the in-flight valid shift register is cleared, and no stale word is ever presented.
- States: IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE: reqReady=1. On accept with reqCount=0, stay in IDLE; no reads and no output. On accept with reqCount>0, latch addr=reqStartAddr and remaining=reqCount, then go to ISSUE.
- ISSUE: reqReady=0. Issue one read per cycle while inFlight+fifoCount < FIFO_DEPTH.
  - On issue: addr increments mod 2^ADDR_W (1023 wraps to 0) and remaining decrements.
  - When the last read issues, go to DRAIN.
- DRAIN: wait until inFlight==0 and the FIFO is empty with its last word popped, then go to IDLE. reqReady rises the cycle after the final pop.
- readEnable is high only on issue cycles. readAddr holds its last value otherwise.
- In-flight tracking: a READ_LATENCY-deep valid shift register.
  - A bit exiting the register pushes readData into the FIFO.
  - The last-flag travels alongside it (set on the final issued read).
- Credit rule: issue is allowed only when inFlight+fifoCount < FIFO_DEPTH, so a push never finds the FIFO full. A simultaneous push and pop in the same cycle keeps fifoCount unchanged.
- Latency: request accepted in cycle T; first readEnable in T+1; first outValid in T+READ_LATENCY+2 (T+4 at defaults).
- Throughput: with outReady held high, one word per cycle with no bubbles after the first.
- Output holds: outData and outLast stay stable while outValid&&!outReady.
- outLast is set only on the final word of each burst and is never set for reqCount=0.

Decomposition:
- Shared package m20k_pkg holds:
  - ADDR_W=10, DATA_W=20, M20K_READ_LATENCY=2;
  - state enum {IDLE, ISSUE, DRAIN};
  - the constant DEFAULT_READER_FIFO_DEPTH=4.
- One sub-module, m20k_reader_fifo: a register-based FIFO holding {last, data} with push, pop, count, empty and full signals.

Test Plan:
- Preload mem[i]=i*3. Request start=5, count=3, outReady=1:
  - readAddr 5,6,7 on T+1..T+3;
  - outData 15,18,21 on T+4..T+6, with outLast only on 21;
  - reqReady returns high at T+7.
- Wrap: start=1022, count=4 -> readAddr 1022,1023,0,1; outData mem[1022],mem[1023],mem[0],mem[1]; outLast on the 4th word.
- Backpressure: count=10, outReady=0 -> at most FIFO_DEPTH=4 readEnable pulses. Then release outReady -> all 10 words arrive in address order, with no loss or duplicates.
- Zero count: reqCount=0 accepted -> no readEnable and no outValid; reqReady stays high in the next cycle.
- Full throughput: start=0, count=1024, outReady=1 -> 1024 consecutive outValid cycles, outLast on mem[1023], reqReady held at 0 throughout.
- Reset mid-burst: assert rst after 3 words have been output of a count=8 burst -> next cycle outValid=0 and readEnable=0. Stale in-flight data never appears. A new request start=100, count=1 then returns mem[100] with outLast=1.
